// File: rtl/hazard_stall_controller_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller_if
// Bundles every pipeline-facing signal of the hazard/stall controller.
//   master : pipeline side; drives register indices and control bits from the
//            ID/EX/MEM/WB stage registers and md_done; receives the controls.
//   slave  : the controller; receives pipeline state, drives enables,
//            flushes, md_go, forwarding selects, md_error and stall_cnt.
// ---------------------------------------------------------------------------
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             use_rs1_id;
  logic             use_rs2_id;
  logic [4:0]       rs1_ex;
  logic [4:0]       rs2_ex;
  logic [4:0]       rd_ex;
  logic             memread_ex;
  logic             md_op_ex;
  logic             md_done;
  logic             branch_taken_ex;
  logic [4:0]       rd_mem;
  logic [4:0]       rd_wb;
  logic             regwrite_mem;
  logic             regwrite_wb;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             md_go;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             md_error;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rs1_ex, rs2_ex, rd_ex,
           memread_ex, md_op_ex, md_done, branch_taken_ex,
           rd_mem, rd_wb, regwrite_mem, regwrite_wb,
    input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush,
           md_go, fwd_a, fwd_b, md_error, stall_cnt
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rs1_ex, rs2_ex, rd_ex,
           memread_ex, md_op_ex, md_done, branch_taken_ex,
           rd_mem, rd_wb, regwrite_mem, regwrite_wb,
    output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush,
           md_go, fwd_a, fwd_b, md_error, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
// Central sequencer for the 5-stage RISC-V pipeline: PC / IF/ID / ID/EX load
// enables, IF/ID / ID/EX / EX/MEM flushes, EX-stage forwarding selects and
// the start/done handshake with the multi-cycle (mul/div) unit.
// Ports:
//   clk   : processor clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hazard_stall_controller_if.slave (pipeline inputs, controls out)
// ---------------------------------------------------------------------------
module hazard_stall_controller #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  hazard_stall_controller_if.slave   bus
);

  typedef enum logic [1:0] {INIT, RUN, MD_WAIT} state_e;

  // The wait counter only ever has to reach MD_TIMEOUT-1.
  localparam int                WAIT_W    = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              md_error_q, md_error_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic stall_cycle;
  logic pc_en, ifid_en, idex_en;
  logic ifid_flush, idex_flush, exmem_flush;
  logic md_go;
  logic [1:0] fwd_a, fwd_b;

  // MEM beats WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_mem,
                                         input logic       wr_mem,
                                         input logic [4:0] rd_wb,
                                         input logic       wr_wb);
    if (wr_mem && (rd_mem != 5'd0) && (rd_mem == rs))
      return 2'b10;
    else if (wr_wb && (rd_wb != 5'd0) && (rd_wb == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // A load in EX whose destination is read by the ID instruction; x0 excluded.
  always_comb begin
    load_use = bus.memread_ex && (bus.rd_ex != 5'd0) &&
               ((bus.use_rs1_id && (bus.rs1_id == bus.rd_ex)) ||
                (bus.use_rs2_id && (bus.rs2_id == bus.rd_ex)));
  end

  // Next-state and pipeline controls. In RUN a taken branch wins over a
  // multi-cycle start, which wins over a load-use stall.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    md_error_d  = md_error_q;
    stall_cycle = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_go       = 1'b0;

    case (state_q)
      INIT: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (bus.branch_taken_ex) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (bus.md_op_ex) begin
          md_go      = 1'b1;
          wait_cnt_d = '0;
          state_d    = MD_WAIT;
        end else if (load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_flush  = 1'b1;
          stall_cycle = 1'b1;
        end
      end
      MD_WAIT: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
        stall_cycle = 1'b1;
        wait_cnt_d  = wait_cnt_q + 1'b1;
        // md_done on the last allowed cycle still counts as success.
        if (bus.md_done) begin
          exmem_flush = 1'b0;
          state_d     = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          md_error_d = 1'b1;
          state_d    = RUN;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Saturating stall counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cycle && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // Forwarding is purely combinational and independent of the FSM state.
  always_comb begin
    fwd_a = fwd_sel(bus.rs1_ex, bus.rd_mem, bus.regwrite_mem, bus.rd_wb, bus.regwrite_wb);
    fwd_b = fwd_sel(bus.rs2_ex, bus.rd_mem, bus.regwrite_mem, bus.rd_wb, bus.regwrite_wb);
  end

  // State registers; reset forces INIT immediately, even mid multi-cycle wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      wait_cnt_q  <= '0;
      md_error_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      md_error_q  <= md_error_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.md_go       = md_go;
  assign bus.fwd_a       = fwd_a;
  assign bus.fwd_b       = fwd_b;
  assign bus.md_error    = md_error_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_controller
// Self-checking bench for hazard_stall_controller: directed scenarios plus a
// randomized run compared against a cycle-level behavioural model.
// ---------------------------------------------------------------------------
module tb_hazard_stall_controller;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 16;
  localparam int STALL_MAX  = (1 << CNT_W) - 1;

  // Control pattern packing: {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, md_go}
  localparam logic [6:0] CTL_INIT   = 7'b000_111_0;
  localparam logic [6:0] CTL_RUN    = 7'b111_000_0;
  localparam logic [6:0] CTL_BRANCH = 7'b111_110_0;
  localparam logic [6:0] CTL_LU     = 7'b001_010_0;
  localparam logic [6:0] CTL_GO     = 7'b111_000_1;
  localparam logic [6:0] CTL_WAIT   = 7'b000_001_0;
  localparam logic [6:0] CTL_DONE   = 7'b000_000_0;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_pass;

  // Behavioural model state
  bit m_init;
  bit m_md_wait;
  int m_md_elapsed;
  int m_stall;
  bit m_err;

  hazard_stall_controller_if #(.CNT_W(CNT_W)) bus ();

  hazard_stall_controller #(
    .MD_TIMEOUT(MD_TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dut_ctl();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.ifid_flush,
            bus.idex_flush, bus.exmem_flush, bus.md_go};
  endfunction

  function automatic bit model_hazard();
    return bus.memread_ex && (bus.rd_ex != 5'd0) &&
           ((bus.use_rs1_id && bus.rs1_id == bus.rd_ex) ||
            (bus.use_rs2_id && bus.rs2_id == bus.rd_ex));
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (bus.regwrite_mem && bus.rd_mem != 5'd0 && bus.rd_mem == rs) return 2'b10;
    if (bus.regwrite_wb && bus.rd_wb != 5'd0 && bus.rd_wb == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected control pattern for the current cycle from the model's phase.
  function automatic logic [6:0] model_ctl();
    if (!rst_n || m_init) return CTL_INIT;
    if (m_md_wait) return bus.md_done ? CTL_DONE : CTL_WAIT;
    if (bus.branch_taken_ex) return CTL_BRANCH;
    if (bus.md_op_ex) return CTL_GO;
    if (model_hazard()) return CTL_LU;
    return CTL_RUN;
  endfunction

  task automatic model_reset();
    m_init       = 1'b1;
    m_md_wait    = 1'b0;
    m_md_elapsed = 0;
    m_stall      = 0;
    m_err        = 1'b0;
  endtask

  // Applies the effect of the coming rising edge to the model.
  task automatic model_advance();
    if (!rst_n) begin
      model_reset();
    end else if (m_init) begin
      m_init = 1'b0;
    end else if (m_md_wait) begin
      if (m_stall < STALL_MAX) m_stall++;
      m_md_elapsed++;
      if (bus.md_done) m_md_wait = 1'b0;
      else if (m_md_elapsed == MD_TIMEOUT) begin
        m_err     = 1'b1;
        m_md_wait = 1'b0;
      end
    end else if (!bus.branch_taken_ex) begin
      if (bus.md_op_ex) begin
        m_md_wait    = 1'b1;
        m_md_elapsed = 0;
      end else if (model_hazard()) begin
        if (m_stall < STALL_MAX) m_stall++;
      end
    end
  endtask

  // Advance one clock; returns 2 time units after the rising edge.
  task automatic tick();
    model_advance();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.rs1_id = '0; bus.rs2_id = '0; bus.use_rs1_id = 0; bus.use_rs2_id = 0;
    bus.rs1_ex = '0; bus.rs2_ex = '0; bus.rd_ex = '0;
    bus.memread_ex = 0; bus.md_op_ex = 0; bus.md_done = 0; bus.branch_taken_ex = 0;
    bus.rd_mem = '0; bus.rd_wb = '0; bus.regwrite_mem = 0; bus.regwrite_wb = 0;
  endtask

  // Reset and step through the INIT cycle; leaves the DUT in RUN.
  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_INIT) $display("[TB] FAIL reset_ctl: got %b expected %b", dut_ctl(), CTL_INIT);
    else n_pass++;
    n_checks++;
    if (bus.stall_cnt !== 16'd0) $display("[TB] FAIL reset_stall: got %0d expected 0", bus.stall_cnt);
    else n_pass++;
    n_checks++;
    if (bus.md_error !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", bus.md_error);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_INIT) $display("[TB] FAIL init_cycle: got %b expected %b", dut_ctl(), CTL_INIT);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_RUN) $display("[TB] FAIL run_after_init: got %b expected %b", dut_ctl(), CTL_RUN);
    else n_pass++;
  endtask

  task automatic test_load_use();
    reset_dut();
    bus.memread_ex = 1; bus.rd_ex = 5'd5; bus.rs1_id = 5'd5; bus.use_rs1_id = 1;
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_LU) $display("[TB] FAIL load_use_stall: got %b expected %b", dut_ctl(), CTL_LU);
    else n_pass++;
    tick();
    bus.memread_ex = 0;
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_RUN) $display("[TB] FAIL load_use_one_cycle: got %b expected %b", dut_ctl(), CTL_RUN);
    else n_pass++;
    n_checks++;
    if (bus.stall_cnt !== 16'd1) $display("[TB] FAIL load_use_cnt: got %0d expected 1", bus.stall_cnt);
    else n_pass++;
    bus.memread_ex = 1; bus.rd_ex = 5'd0; bus.rs1_id = 5'd0;
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_RUN) $display("[TB] FAIL load_use_x0: got %b expected %b", dut_ctl(), CTL_RUN);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (bus.stall_cnt !== 16'd1) $display("[TB] FAIL load_use_x0_cnt: got %0d expected 1", bus.stall_cnt);
    else n_pass++;
  endtask

  task automatic test_branch_priority();
    reset_dut();
    bus.memread_ex = 1; bus.rd_ex = 5'd5; bus.rs1_id = 5'd5; bus.use_rs1_id = 1;
    bus.branch_taken_ex = 1;
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_BRANCH) $display("[TB] FAIL branch_over_lu: got %b expected %b", dut_ctl(), CTL_BRANCH);
    else n_pass++;
    bus.md_op_ex = 1;
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_BRANCH) $display("[TB] FAIL branch_over_md: got %b expected %b", dut_ctl(), CTL_BRANCH);
    else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if ({dut_ctl(), bus.stall_cnt} !== {CTL_RUN, 16'd0})
      $display("[TB] FAIL branch_no_stall: got ctl %b cnt %0d expected ctl %b cnt 0", dut_ctl(), bus.stall_cnt, CTL_RUN);
    else n_pass++;
  endtask

  task automatic test_multicycle();
    reset_dut();
    bus.md_op_ex = 1;
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_GO) $display("[TB] FAIL md_go_pulse: got %b expected %b", dut_ctl(), CTL_GO);
    else n_pass++;
    tick();
    bus.md_op_ex = 0;
    for (int k = 0; k < 5; k++) begin
      bus.md_done = (k == 4);
      #1;
      n_checks++;
      if (dut_ctl() !== ((k == 4) ? CTL_DONE : CTL_WAIT))
        $display("[TB] FAIL md_wait_%0d: got %b expected %b", k, dut_ctl(), (k == 4) ? CTL_DONE : CTL_WAIT);
      else n_pass++;
      tick();
    end
    bus.md_done = 0;
    #1;
    n_checks++;
    if ({dut_ctl(), bus.stall_cnt, bus.md_error} !== {CTL_RUN, 16'd5, 1'b0})
      $display("[TB] FAIL md_return: got ctl %b cnt %0d err %b expected ctl %b cnt 5 err 0",
               dut_ctl(), bus.stall_cnt, bus.md_error, CTL_RUN);
    else n_pass++;
    bus.md_done = 1;
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_RUN) $display("[TB] FAIL md_done_in_run: got %b expected %b", dut_ctl(), CTL_RUN);
    else n_pass++;
    tick();
    bus.md_done = 0;
  endtask

  task automatic test_timeout();
    reset_dut();
    bus.md_op_ex = 1;
    tick();
    bus.md_op_ex = 0;
    for (int k = 0; k < MD_TIMEOUT; k++) begin
      #1;
      n_checks++;
      if ({dut_ctl(), bus.md_error} !== {CTL_WAIT, 1'b0})
        $display("[TB] FAIL timeout_wait_%0d: got ctl %b err %b expected ctl %b err 0", k, dut_ctl(), bus.md_error, CTL_WAIT);
      else n_pass++;
      tick();
    end
    #1;
    n_checks++;
    if ({dut_ctl(), bus.md_error, bus.stall_cnt} !== {CTL_RUN, 1'b1, 16'd8})
      $display("[TB] FAIL timeout_abort: got ctl %b err %b cnt %0d expected ctl %b err 1 cnt 8",
               dut_ctl(), bus.md_error, bus.stall_cnt, CTL_RUN);
    else n_pass++;
    // A later successful operation must not clear the sticky flag.
    bus.md_op_ex = 1;
    tick();
    bus.md_op_ex = 0;
    bus.md_done  = 1;
    tick();
    bus.md_done  = 0;
    repeat (3) tick();
    #1;
    n_checks++;
    if (bus.md_error !== 1'b1) $display("[TB] FAIL timeout_sticky: got %b expected 1", bus.md_error);
    else n_pass++;
    reset_dut();
    #1;
    n_checks++;
    if (bus.md_error !== 1'b0) $display("[TB] FAIL timeout_cleared: got %b expected 0", bus.md_error);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wait();
    reset_dut();
    bus.md_op_ex = 1;
    tick();
    bus.md_op_ex = 0;
    tick();
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_INIT) $display("[TB] FAIL rst_mid_wait: got %b expected %b", dut_ctl(), CTL_INIT);
    else n_pass++;
    bus.md_done = 1;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (dut_ctl() !== CTL_INIT) $display("[TB] FAIL rst_init_ignores_done: got %b expected %b", dut_ctl(), CTL_INIT);
    else n_pass++;
    tick();
    bus.md_done = 0;
    #1;
    n_checks++;
    if ({dut_ctl(), bus.stall_cnt} !== {CTL_RUN, 16'd0})
      $display("[TB] FAIL rst_back_to_run: got ctl %b cnt %0d expected ctl %b cnt 0", dut_ctl(), bus.stall_cnt, CTL_RUN);
    else n_pass++;
  endtask

  task automatic test_forwarding();
    clear_inputs();
    bus.rs1_ex = 5'd7; bus.rd_mem = 5'd7; bus.rd_wb = 5'd7;
    bus.regwrite_mem = 1; bus.regwrite_wb = 1;
    #1;
    n_checks++;
    if (bus.fwd_a !== 2'b10) $display("[TB] FAIL fwd_mem_priority: got %b expected 10", bus.fwd_a);
    else n_pass++;
    bus.regwrite_mem = 0;
    #1;
    n_checks++;
    if (bus.fwd_a !== 2'b01) $display("[TB] FAIL fwd_wb: got %b expected 01", bus.fwd_a);
    else n_pass++;
    bus.rs2_ex = 5'd0; bus.rd_mem = 5'd0; bus.regwrite_mem = 1;
    #1;
    n_checks++;
    if (bus.fwd_b !== 2'b00) $display("[TB] FAIL fwd_x0_mem: got %b expected 00", bus.fwd_b);
    else n_pass++;
    bus.rs2_ex = 5'd7; bus.rd_mem = 5'd3;
    #1;
    n_checks++;
    if (bus.fwd_b !== 2'b01) $display("[TB] FAIL fwd_b_wb: got %b expected 01", bus.fwd_b);
    else n_pass++;
    bus.rs1_ex = 5'd0; bus.rd_wb = 5'd0;
    #1;
    n_checks++;
    if (bus.fwd_a !== 2'b00) $display("[TB] FAIL fwd_x0_wb: got %b expected 00", bus.fwd_a);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    logic [6:0] exp_ctl;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      bus.rs1_id          = 5'($urandom_range(0, 3));
      bus.rs2_id          = 5'($urandom_range(0, 3));
      bus.use_rs1_id      = 1'($urandom_range(0, 1));
      bus.use_rs2_id      = 1'($urandom_range(0, 1));
      bus.rs1_ex          = 5'($urandom_range(0, 3));
      bus.rs2_ex          = 5'($urandom_range(0, 3));
      bus.rd_ex           = 5'($urandom_range(0, 3));
      bus.memread_ex      = 1'($urandom_range(0, 1));
      bus.md_op_ex        = ($urandom_range(0, 7) == 0);
      bus.md_done         = ($urandom_range(0, 3) == 0);
      bus.branch_taken_ex = ($urandom_range(0, 5) == 0);
      bus.rd_mem          = 5'($urandom_range(0, 3));
      bus.rd_wb           = 5'($urandom_range(0, 3));
      bus.regwrite_mem    = 1'($urandom_range(0, 1));
      bus.regwrite_wb     = 1'($urandom_range(0, 1));
      #1;
      exp_ctl = model_ctl();
      n_checks++;
      if (dut_ctl() !== exp_ctl) $display("[TB] FAIL rand_ctl_%0d: got %b expected %b", c, dut_ctl(), exp_ctl);
      else n_pass++;
      n_checks++;
      if ({bus.fwd_a, bus.fwd_b} !== {model_fwd(bus.rs1_ex), model_fwd(bus.rs2_ex)})
        $display("[TB] FAIL rand_fwd_%0d: got %b/%b expected %b/%b", c, bus.fwd_a, bus.fwd_b,
                 model_fwd(bus.rs1_ex), model_fwd(bus.rs2_ex));
      else n_pass++;
      n_checks++;
      if ({bus.stall_cnt, bus.md_error} !== {16'(m_stall), m_err})
        $display("[TB] FAIL rand_cnt_%0d: got cnt %0d err %b expected cnt %0d err %b", c,
                 bus.stall_cnt, bus.md_error, m_stall, m_err);
      else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_multicycle();
    test_timeout();
    test_reset_mid_wait();
    test_forwarding();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
